switch_debouncer: RTL and testbench
===================================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001: The module SHALL have parameter WIDTH, default 4, giving the number of switch bits debounced.
REQ-002: The module SHALL have parameter DEBOUNCE_CNT, default 240000, giving the consecutive clk cycles a new level must persist; 5 ms at 48 MHz.
REQ-003: The module SHALL have port clk, input, 1 bit, system clock; all flops are on its rising edge.
REQ-004: The module SHALL have port nreset, input, 1 bit, asynchronous active-low reset.
REQ-005: The module SHALL have port s_raw, input, WIDTH bits, raw asynchronous DIP-switch levels.
REQ-006: The module SHALL have port s_db, output, WIDTH bits, debounced switch levels; drives the downstream LED/seven-segment logic switch input directly.
REQ-007: The module SHALL have port rise, output, WIDTH bits, one-cycle pulse per bit on accepted 0->1.
REQ-008: The module SHALL have port fall, output, WIDTH bits, one-cycle pulse per bit on accepted 1->0.
REQ-009: The module SHALL have port changed, output, 1 bit, OR of all rise and fall bits.

Function
REQ-010: Each s_raw bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-011: Each bit SHALL have an independent counter of width ceil(log2(DEBOUNCE_CNT)); bits SHALL NOT share or influence each other's counters or outputs.
REQ-012: Per bit, when sync2 equals s_db, the counter SHALL be cleared to 0 on the next edge.
REQ-013: Per bit, when sync2 differs from s_db and the counter is below DEBOUNCE_CNT-1, the counter SHALL increment by 1 on the next edge.
REQ-014: Per bit, when sync2 differs from s_db and the counter equals DEBOUNCE_CNT-1, then on the next edge s_db SHALL take sync2's value and the counter SHALL clear to 0.
REQ-015: The counter SHALL never exceed DEBOUNCE_CNT-1 and SHALL never wrap.
REQ-016: The latency SHALL be as follows for a level held stable: s_db updates on the (DEBOUNCE_CNT+1)th rising edge after the edge on which sync1 first captures it.
REQ-017: Glitch rejection: any single cycle in which sync2 returns to s_db's value SHALL discard all accumulated count; no partial credit.
REQ-018: rise[i] SHALL be registered, high for exactly the one cycle following the edge at which s_db[i] goes 0->1, and low otherwise.
REQ-019: fall[i] SHALL be registered, high for exactly the one cycle following the edge at which s_db[i] goes 1->0, and low otherwise.
REQ-020: rise[i] and fall[i] SHALL never be high in the same cycle.
REQ-021: changed SHALL equal |(rise|fall), combinational from the registered pulses.
REQ-022: Simultaneous qualifying changes on several bits SHALL update those s_db bits, and assert their pulses, on the same edge.
REQ-023: DEBOUNCE_CNT values below 2 are unsupported; the design SHALL be correct for all DEBOUNCE_CNT >= 2 and WIDTH >= 1.

Reset
REQ-024: While nreset is low, sync1, sync2, s_db, all counters, rise, fall and changed SHALL be 0, asynchronously and independent of clk.
REQ-025: Reset asserted mid-count SHALL discard the count.
REQ-026: After reset release, a bit whose s_raw is held 1 SHALL be treated as a new 0->1 change: full latency per REQ-016, followed by a rise pulse.
REQ-027: No output SHALL pulse as a direct result of reset assertion or release alone.

Verification
REQ-028: Basic accept: DEBOUNCE_CNT=4; after reset, s_raw 0000->0001 held -> s_db=0001 on 5th edge after sync1 capture; rise=0001 and changed=1 for exactly the next cycle.
REQ-029: Glitch reject: DEBOUNCE_CNT=4; s_db=0000; s_raw[2]=1 for 3 sync2 cycles, then 0 for 1 cycle, then 1 held -> s_db stays 0000 until 4 further consecutive cycles, then 0100.
REQ-030: Release: DEBOUNCE_CNT=4; s_db=1111; s_raw 1111->1010 held -> s_db=1010 after full latency; fall=0101 for one cycle; rise=0000 throughout.
REQ-031: Multi-bit independence: DEBOUNCE_CNT=4; s_raw[0] changes 2 cycles before s_raw[3], both held -> s_db[0] updates 2 cycles before s_db[3]; each has its own single pulse.
REQ-032: Reset mid-count: DEBOUNCE_CNT=4; counter at 2, nreset pulsed low between edges -> all outputs 0 immediately; after release with s_raw=0011 held, s_db=0011 only after full latency.
REQ-033: Default parameter: DEBOUNCE_CNT=240000 at 48 MHz; 1 ms bounce train of 10 us toggles, then stable 1 -> exactly one rise pulse, 240001 edges after sync1 first captures the final stable level.

Source files
------------

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-bit two-flop synchronizer followed by a saturating
// persistence counter. A bit's debounced level changes only after the
// synchronized level has differed from it for DEBOUNCE_CNT consecutive
// cycles. Each accepted change produces a one-cycle rise or fall pulse.
module switch_debouncer #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned DEBOUNCE_CNT = 240000
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] s_raw,
  output logic [WIDTH-1:0] s_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [WIDTH-1:0]            sync1_q;
  logic [WIDTH-1:0]            sync2_q;
  logic [WIDTH-1:0]            s_db_q;
  logic [WIDTH-1:0]            s_db_d;
  logic [WIDTH-1:0]            rise_q;
  logic [WIDTH-1:0]            rise_d;
  logic [WIDTH-1:0]            fall_q;
  logic [WIDTH-1:0]            fall_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;

  // Two-flop synchronizer on the raw asynchronous switch levels
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= s_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit persistence counting; any cycle agreeing with s_db clears the count
  always_comb begin
    s_db_d = s_db_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2_q[i] != s_db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          s_db_d[i] = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced level, counters and edge pulses
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s_db_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      cnt_q  <= '0;
    end else begin
      s_db_q <= s_db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign s_db    = s_db_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = |(rise_q | fall_q);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: a WIDTH=4/DEBOUNCE_CNT=4 instance and a
// WIDTH=1/DEBOUNCE_CNT=2 instance at the minimum supported count.
module tb_switch_debouncer;

  logic       clk;
  logic       nreset;
  logic [3:0] s_raw;
  logic [3:0] s_db;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       changed;

  logic [0:0] m_raw;
  logic [0:0] m_db;
  logic [0:0] m_rise;
  logic [0:0] m_fall;
  logic       m_changed;

  int checks = 0;
  int errors = 0;

  switch_debouncer #(.WIDTH(4), .DEBOUNCE_CNT(4)) dut (
    .clk     (clk),
    .nreset  (nreset),
    .s_raw   (s_raw),
    .s_db    (s_db),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  switch_debouncer #(.WIDTH(1), .DEBOUNCE_CNT(2)) dut_min (
    .clk     (clk),
    .nreset  (nreset),
    .s_raw   (m_raw),
    .s_db    (m_db),
    .rise    (m_rise),
    .fall    (m_fall),
    .changed (m_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    s_raw  = 4'b0000;
    m_raw  = 1'b0;
    repeat (3) tick();
    checks++;
    if ({s_db, rise, fall, changed} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outputs got db=%b r=%b f=%b c=%b exp all 0", s_db, rise, fall, changed);
    end
    checks++;
    if ({m_db, m_rise, m_fall, m_changed} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs_min got db=%b r=%b f=%b c=%b exp all 0", m_db, m_rise, m_fall, m_changed);
    end
    nreset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if ({s_db, rise, fall, changed} !== 13'b0) begin
        errors++;
        $display("FAIL release_quiet k=%0d got db=%b r=%b f=%b c=%b exp all 0", k, s_db, rise, fall, changed);
      end
    end
  endtask

  task automatic test_basic_accept();
    logic [3:0] exp_db;
    logic [3:0] exp_rise;
    s_raw = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_db   = (k >= 6) ? 4'b0001 : 4'b0000;
      exp_rise = (k == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (s_db !== exp_db || rise !== exp_rise || fall !== 4'b0000 || changed !== (k == 6)) begin
        errors++;
        $display("FAIL basic_accept k=%0d got db=%b r=%b f=%b c=%b exp db=%b r=%b f=0000 c=%b",
                 k, s_db, rise, fall, changed, exp_db, exp_rise, (k == 6));
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] exp_db;
    logic [3:0] exp_rise;
    for (int k = 1; k <= 12; k++) begin
      s_raw = (k <= 3 || k >= 5) ? 4'b0101 : 4'b0001;
      tick();
      exp_db   = (k >= 10) ? 4'b0101 : 4'b0001;
      exp_rise = (k == 10) ? 4'b0100 : 4'b0000;
      checks++;
      if (s_db !== exp_db || rise !== exp_rise || fall !== 4'b0000 || changed !== (k == 10)) begin
        errors++;
        $display("FAIL glitch k=%0d got db=%b r=%b f=%b c=%b exp db=%b r=%b f=0000 c=%b",
                 k, s_db, rise, fall, changed, exp_db, exp_rise, (k == 10));
      end
    end
  endtask

  task automatic test_release();
    logic [3:0] exp_db;
    logic [3:0] exp_fall;
    s_raw = 4'b1111;
    repeat (8) tick();
    checks++;
    if (s_db !== 4'b1111 || changed !== 1'b0) begin
      errors++;
      $display("FAIL release_setup got db=%b c=%b exp db=1111 c=0", s_db, changed);
    end
    s_raw = 4'b1010;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_db   = (k >= 6) ? 4'b1010 : 4'b1111;
      exp_fall = (k == 6) ? 4'b0101 : 4'b0000;
      checks++;
      if (s_db !== exp_db || fall !== exp_fall || rise !== 4'b0000 || changed !== (k == 6)) begin
        errors++;
        $display("FAIL release k=%0d got db=%b r=%b f=%b c=%b exp db=%b r=0000 f=%b c=%b",
                 k, s_db, rise, fall, changed, exp_db, exp_fall, (k == 6));
      end
    end
  endtask

  task automatic test_multi_bit();
    logic [3:0] exp_db;
    logic [3:0] exp_rise;
    logic [3:0] exp_fall;
    for (int k = 1; k <= 10; k++) begin
      s_raw = {(k >= 3) ? 1'b0 : 1'b1, 1'b0, 1'b1, 1'b1};
      tick();
      exp_db   = (k >= 8) ? 4'b0011 : ((k >= 6) ? 4'b1011 : 4'b1010);
      exp_rise = (k == 6) ? 4'b0001 : 4'b0000;
      exp_fall = (k == 8) ? 4'b1000 : 4'b0000;
      checks++;
      if (s_db !== exp_db || rise !== exp_rise || fall !== exp_fall || changed !== (k == 6 || k == 8)) begin
        errors++;
        $display("FAIL multi_bit k=%0d got db=%b r=%b f=%b c=%b exp db=%b r=%b f=%b c=%b",
                 k, s_db, rise, fall, changed, exp_db, exp_rise, exp_fall, (k == 6 || k == 8));
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] exp_db;
    logic [3:0] exp_rise;
    s_raw = 4'b0000;
    repeat (3) tick();
    checks++;
    if (s_db !== 4'b0011) begin
      errors++;
      $display("FAIL mid_count_hold got db=%b exp 0011", s_db);
    end
    #2;
    nreset = 1'b0;
    #1;
    checks++;
    if ({s_db, rise, fall, changed} !== 13'b0) begin
      errors++;
      $display("FAIL async_reset got db=%b r=%b f=%b c=%b exp all 0", s_db, rise, fall, changed);
    end
    s_raw = 4'b0011;
    #2;
    nreset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_db   = (k >= 6) ? 4'b0011 : 4'b0000;
      exp_rise = (k == 6) ? 4'b0011 : 4'b0000;
      checks++;
      if (s_db !== exp_db || rise !== exp_rise || fall !== 4'b0000 || changed !== (k == 6)) begin
        errors++;
        $display("FAIL post_reset k=%0d got db=%b r=%b f=%b c=%b exp db=%b r=%b f=0000 c=%b",
                 k, s_db, rise, fall, changed, exp_db, exp_rise, (k == 6));
      end
    end
  endtask

  task automatic test_min_count();
    m_raw = 1'b1;
    tick();
    m_raw = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      tick();
      checks++;
      if (m_db !== 1'b0 || m_rise !== 1'b0 || m_changed !== 1'b0) begin
        errors++;
        $display("FAIL min_glitch k=%0d got db=%b r=%b c=%b exp 0 0 0", k, m_db, m_rise, m_changed);
      end
    end
    m_raw = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (m_db !== ((k >= 4) ? 1'b1 : 1'b0) || m_rise !== ((k == 4) ? 1'b1 : 1'b0) ||
          m_fall !== 1'b0 || m_changed !== (k == 4)) begin
        errors++;
        $display("FAIL min_rise k=%0d got db=%b r=%b f=%b c=%b exp db=%b r=%b f=0 c=%b",
                 k, m_db, m_rise, m_fall, m_changed, (k >= 4), (k == 4), (k == 4));
      end
    end
    m_raw = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (m_db !== ((k >= 4) ? 1'b0 : 1'b1) || m_fall !== ((k == 4) ? 1'b1 : 1'b0) ||
          m_rise !== 1'b0 || m_changed !== (k == 4)) begin
        errors++;
        $display("FAIL min_fall k=%0d got db=%b r=%b f=%b c=%b exp db=%b r=0 f=%b c=%b",
                 k, m_db, m_rise, m_fall, m_changed, (k < 4), (k == 4), (k == 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_accept();
    test_glitch();
    test_release();
    test_multi_bit();
    test_reset_mid_count();
    test_min_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
